silife_load_sequencer: RTL
==========================

// Module: silife_load_sequencer
// PURPOSE
//  Host-side master for the SPI-like grid load bus, clocked by the fast serial clock.
//  Turns configure and write commands plus a row-data stream into bit-exact frames.
//  Drives cs/clk/data into the first loader of the segment daisy chain.
//  Bus clock is i_load_clk/2; one bus bit = 2 i_load_clk cycles.
// PARAMETERS
//  WIDTH   32  cells per row; data bits per row word
//  CS_GAP  4   i_load_clk cycles o_load_cs stays high between frames (>=1)
// PORTS
//  i_load_clk     in   1      clock; all state changes on posedge
//  reset          in   1      asynchronous, active-high
//  i_cmd_valid    in   1      command request
//  o_cmd_ready    out  1      high only in IDLE
//  i_cmd_op       in   1      0=configure frame, 1=write frame
//  i_cmd_segment  in   15     write: segment address; 15'h7fff=broadcast
//  i_cmd_row      in   16     write: first row address
//  i_cmd_count    in   16     write: rows to send; configure: number of '1' bits
//  i_row_valid    in   1      row word available
//  o_row_ready    out  1      high only in ROW_WAIT
//  i_row_data     in   WIDTH  row word; bit WIDTH-1 is sent first
//  i_abort        in   1      synchronous frame abort
//  o_load_cs      out  1      bus chip select, active-low
//  o_load_clk     out  1      bus clock
//  o_load_data    out  1      bus data
//  o_busy         out  1      high whenever state != IDLE
//  o_frame_done   out  1      1-cycle pulse on the edge o_load_cs rises at frame end/abort
// BEHAVIOUR
//  Reset/IDLE
//  - Outputs: cs=1, clk=0, data=0, cmd_ready=1, row_ready=0, busy=0, done=0.
//  - Reset mid-frame returns to these values immediately. No partial bit is completed.
//  - All outputs are registered.
//  Command accept
//  - Accept on valid&&ready; command fields are latched at acceptance.
//  - Same edge: cs=0, clk=0, data=header bit (configure=1, write=0).
//  Bit timing
//  - Each bus bit has a LOW phase (clk=0, new data) then a HIGH phase (clk=1, data held).
//  - Data changes only in LOW phases. cs changes only when clk=0.
//  States
//  - IDLE -> HDR -> {CFG | SEG}.
//  - CFG: i_cmd_count ones, then one terminating '0' -> END.
//  - SEG: 15 bits, MSB first -> ROW. ROW: 16 bits, MSB first.
//  - After ROW: go to ROW_WAIT if count>0, else END.
//  - ROW_WAIT: clk=0, data holds its last value, row_ready=1. Stalls indefinitely.
//    On valid&&ready, latch the word into the shift register.
//  - DATA: the cycle after acceptance is the LOW phase of bit WIDTH-1; WIDTH bits, MSB first.
//    After the HIGH phase of bit 0, decrement rows remaining.
//    Go to ROW_WAIT if >0, else END. Row addressing is done by the loaders; no row bits are resent.
//  - END: cs=1, clk=0, data=0, done=1 for 1 cycle -> GAP.
//  - GAP: CS_GAP-1 further cycles -> IDLE.
//  Abort
//  - i_abort in any state except IDLE/END/GAP: next edge performs the END actions.
//  - clk is driven 0 on that edge even if it was mid-HIGH phase. The partial bit is dropped.
//  - i_abort in IDLE is ignored and has priority over command accept only when busy.
//  Frame lengths (cycles from accept edge to END edge)
//  - Configure: 2*(count+2).
//  - Write, no stalls: 64 + count*(2*WIDTH+1).
//  - count=0 write: header + addresses only, 64 cycles.
//  - count=0 configure: bits "10".
//  Counters and widths
//  - Rows and ones counters are 16-bit, no wrap: count=16'hFFFF is honoured exactly.
//  - Bit counter is sized max(clog2(WIDTH),4) bits.
// TESTING (bench WIDTH=8, CS_GAP=4; a bus decoder samples data on clk rise while cs=0)
//  - Configure, count=3: bus bits 1,1,1,1,0. cs low 10 cycles. done pulse. ready again 4 cycles after cs rise.
//  - Write seg=0x0005, row=0x0002, count=2, rows 0xA5,0x3C, valid held:
//    bits 0, 000000000000101, 0000000000000010, 10100101, 00111100. END at cycle 98.
//  - Same write with second row_valid delayed 10 cycles: clk stays 0, cs stays 0, data stable.
//    Bus bit sequence identical.
//  - Broadcast write seg=0x7fff, count=0: 32 bits (0 then 15 ones then row), no row_ready.
//  - i_abort during SEG HIGH phase: next edge cs=1, clk=0, done=1. Later command starts clean frame.
//  - Async reset asserted mid-DATA: cs=1, clk=0, busy=0 immediately. i_cmd_valid accepted first edge after release.

Source files
------------

// File: rtl/silife_load_sequencer_if.sv
// Host-side grid load bus bundle: command and row-data handshakes, abort,
// and the serial cs/clk/data outputs with frame status.
interface silife_load_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_op;
  logic [14:0]      i_cmd_segment;
  logic [15:0]      i_cmd_row;
  logic [15:0]      i_cmd_count;
  logic             i_row_valid;
  logic             o_row_ready;
  logic [WIDTH-1:0] i_row_data;
  logic             i_abort;
  logic             o_load_cs;
  logic             o_load_clk;
  logic             o_load_data;
  logic             o_busy;
  logic             o_frame_done;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_segment, i_cmd_row, i_cmd_count,
    output i_row_valid, i_row_data, i_abort,
    input  o_cmd_ready, o_row_ready, o_load_cs, o_load_clk, o_load_data,
    input  o_busy, o_frame_done
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_segment, i_cmd_row, i_cmd_count,
    input  i_row_valid, i_row_data, i_abort,
    output o_cmd_ready, o_row_ready, o_load_cs, o_load_clk, o_load_data,
    output o_busy, o_frame_done
  );
endinterface

// File: rtl/silife_load_sequencer.sv
// Grid load bus master: serialises configure/write commands and row words into
// cs/clk/data frames, one bus bit per two i_load_clk cycles (LOW then HIGH phase).
module silife_load_sequencer #(
  parameter int WIDTH  = 32,
  parameter int CS_GAP = 4
) (
  input logic                    i_load_clk,
  input logic                    reset,
  silife_load_sequencer_if.slave bus
);
  localparam int BW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;
  localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam logic [BW-1:0] SEG_LAST  = BW'(14);
  localparam logic [BW-1:0] ROW_LAST  = BW'(15);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT  = (CS_GAP > 1) ? GW'(CS_GAP - 2) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CFG, S_SEG, S_ROW, S_RWAIT, S_DATA, S_END, S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_cs, r_clk, r_data, r_cmd_ready, r_row_ready, r_busy, r_done;
  logic             w_cs_nxt, w_clk_nxt, w_data_nxt, w_cmd_ready_nxt;
  logic             w_row_ready_nxt, w_busy_nxt, w_done_nxt;
  logic [BW-1:0]    r_cnt;
  logic [15:0]      r_remain;
  logic [GW-1:0]    r_gap;
  logic             r_op;
  logic [30:0]      r_addr;
  logic [WIDTH-1:0] r_shift;
  logic             w_cmd_acc, w_row_acc, w_abort, w_bit_state;

  assign w_cmd_acc   = bus.i_cmd_valid && r_cmd_ready;
  assign w_row_acc   = bus.i_row_valid && r_row_ready;
  assign w_abort     = bus.i_abort &&
                       (r_state inside {S_HDR, S_CFG, S_SEG, S_ROW, S_RWAIT, S_DATA});
  assign w_bit_state = r_state inside {S_HDR, S_CFG, S_SEG, S_ROW, S_DATA};

  always_ff @(posedge i_load_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_clk high means the HIGH phase just ran; the next edge starts a new bit.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cmd_acc) w_state_nxt = S_HDR;
      S_HDR:   if (r_clk) w_state_nxt = r_op ? S_SEG : S_CFG;
      S_CFG:   if (r_clk && !r_data) w_state_nxt = S_END;
      S_SEG:   if (r_clk && r_cnt == '0) w_state_nxt = S_ROW;
      S_ROW:   if (r_clk && r_cnt == '0)
                 w_state_nxt = (r_remain != 16'd0) ? S_RWAIT : S_END;
      S_RWAIT: if (w_row_acc) w_state_nxt = S_DATA;
      S_DATA:  if (r_clk && r_cnt == '0)
                 w_state_nxt = (r_remain != 16'd1) ? S_RWAIT : S_END;
      S_END:   w_state_nxt = (CS_GAP > 1) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_END;
  end

  always_comb begin
    w_cs_nxt        = !(w_state_nxt inside {S_IDLE, S_END, S_GAP});
    w_cs_nxt        = !w_cs_nxt;
    w_clk_nxt       = (w_state_nxt == r_state) && w_bit_state && !r_clk;
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_row_ready_nxt = (w_state_nxt == S_RWAIT);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_END);
    w_data_nxt      = r_data;
    unique case (r_state)
      S_IDLE:       if (w_cmd_acc) w_data_nxt = ~bus.i_cmd_op;
      S_HDR:        if (r_clk) w_data_nxt = r_op ? r_addr[30] : (r_remain != 16'd0);
      S_CFG:        if (r_clk) w_data_nxt = (r_remain != 16'd0);
      S_SEG:        if (r_clk) w_data_nxt = r_addr[30];
      S_ROW:        if (r_clk && r_cnt != '0) w_data_nxt = r_addr[30];
      S_RWAIT:      if (w_row_acc) w_data_nxt = bus.i_row_data[WIDTH-1];
      S_DATA:       if (r_clk && r_cnt != '0) w_data_nxt = r_shift[WIDTH-1];
      default:      w_data_nxt = r_data;
    endcase
    if (!w_cs_nxt == 1'b0) w_data_nxt = 1'b0;
  end

  always_ff @(posedge i_load_clk or posedge reset) begin
    if (reset) begin
      r_cs        <= 1'b1;
      r_clk       <= 1'b0;
      r_data      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_row_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cs        <= w_cs_nxt;
      r_clk       <= w_clk_nxt;
      r_data      <= w_data_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_row_ready <= w_row_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // r_remain counts ones still to send (configure) or rows still to send (write).
  always_ff @(posedge i_load_clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_remain <= '0;
      r_gap    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_cmd_acc) r_remain <= bus.i_cmd_count;
        S_HDR:   if (r_clk) begin
                   if (r_op) r_cnt <= SEG_LAST;
                   else if (r_remain != 16'd0) r_remain <= r_remain - 16'd1;
                 end
        S_CFG:   if (r_clk && r_data && r_remain != 16'd0) r_remain <= r_remain - 16'd1;
        S_SEG:   if (r_clk) r_cnt <= (r_cnt == '0) ? ROW_LAST : r_cnt - 1'b1;
        S_ROW:   if (r_clk && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_RWAIT: if (w_row_acc) r_cnt <= DATA_LAST;
        S_DATA:  if (r_clk) begin
                   if (r_cnt == '0) r_remain <= r_remain - 16'd1;
                   else             r_cnt    <= r_cnt - 1'b1;
                 end
        S_END:   r_gap <= GAP_INIT;
        S_GAP:   if (r_gap != '0) r_gap <= r_gap - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_load_clk) begin
    if (r_state == S_IDLE && w_cmd_acc) begin
      r_op   <= bus.i_cmd_op;
      r_addr <= {bus.i_cmd_segment, bus.i_cmd_row};
    end else if (r_clk && r_state inside {S_HDR, S_SEG, S_ROW}) begin
      r_addr <= r_addr << 1;
    end
    if (r_state == S_RWAIT && w_row_acc) r_shift <= bus.i_row_data << 1;
    else if (r_state == S_DATA && r_clk) r_shift <= r_shift << 1;
  end

  assign bus.o_load_cs    = r_cs;
  assign bus.o_load_clk   = r_clk;
  assign bus.o_load_data  = r_data;
  assign bus.o_cmd_ready  = r_cmd_ready;
  assign bus.o_row_ready  = r_row_ready;
  assign bus.o_busy       = r_busy;
  assign bus.o_frame_done = r_done;
endmodule
